tone_sequencer: RTL and testbench

Note sequencer that drives the `period` input of a `tone` generator. It holds a small writable note table, where each entry is a period in µs and a duration in ms. On `start` it plays the entries in order, inserts a fixed silent gap between notes, and then either stops or loops. It sits between a control source (switches, buttons or a CPU register bank) and one `tone` instance; the top level gates `tone_out` with `tone_en`.

---
 rtl/tone_sequencer.sv | 173 +++++++++++++++++
 tb/tb_tone_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/tone_sequencer.sv
// Plays a writable table of {period_us, dur_ms} notes into a tone generator, with a fixed gap between notes.
// period/tone_en follow start by 2 cycles, stop takes effect on the next edge; table writes are accepted in every state.
module tone_sequencer #(
  parameter int CLKS_PER_US = 100,
  parameter int US_PER_MS   = 1000,
  parameter int GAP_MS      = 10,
  parameter int DEPTH       = 16,
  localparam int AW         = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [15:0]   wr_period,
  input  logic [11:0]   wr_dur,
  input  logic          start,
  input  logic          stop,
  input  logic          loop,
  output logic [31:0]   period,
  output logic          tone_en,
  output logic          busy,
  output logic [AW-1:0] note_idx,
  output logic          done
);

  localparam int             T        = CLKS_PER_US * US_PER_MS;
  localparam int             CW       = (T > 1) ? $clog2(T) : 1;
  localparam logic [CW-1:0]  T_LAST   = CW'(T - 1);
  localparam logic [11:0]    GAP_LAST = 12'(GAP_MS - 1);
  localparam logic [AW-1:0]  IDX_LAST = AW'(DEPTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_PLAY, S_GAP} state_e;

  logic [27:0] tbl_q [DEPTH];

  state_e        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [11:0]   dur_q, dur_d;
  logic [15:0]   period_q, period_d;
  logic          tone_en_q, tone_en_d;
  logic          done_q, done_d;
  logic          played_q, played_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [11:0]   ms_q, ms_d;

  logic [27:0]   entry;
  logic          tick;
  logic          advance;
  logic          end_seq;

  // Table is deliberately not reset; software must fill it before start.
  always_ff @(posedge CLK) begin
    if (wr_en) tbl_q[wr_addr] <= {wr_period, wr_dur};
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    dur_d     = dur_q;
    period_d  = period_q;
    tone_en_d = tone_en_q;
    played_d  = played_q;
    done_d    = 1'b0;
    cyc_d     = '0;
    ms_d      = '0;
    advance   = 1'b0;
    end_seq   = 1'b0;
    entry     = tbl_q[idx_q];
    tick      = (cyc_q == T_LAST);

    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          state_d  = S_LOAD;
          idx_d    = '0;
          played_d = 1'b0;
        end
      end
      S_LOAD: begin
        if (entry[11:0] == 12'd0) begin
          end_seq = 1'b1;
        end else begin
          state_d   = S_PLAY;
          dur_d     = entry[11:0];
          period_d  = entry[27:12];
          tone_en_d = (entry[27:12] != 16'd0);
          played_d  = 1'b1;
        end
      end
      S_PLAY: begin
        if (tick && ms_q == dur_q - 12'd1) begin
          tone_en_d = 1'b0;
          period_d  = '0;
          if (GAP_MS > 0) state_d = S_GAP;
          else            advance = 1'b1;
        end else begin
          cyc_d = tick ? '0 : cyc_q + 1'b1;
          ms_d  = tick ? ms_q + 12'd1 : ms_q;
        end
      end
      S_GAP: begin
        if (tick && ms_q == GAP_LAST) begin
          advance = 1'b1;
        end else begin
          cyc_d = tick ? '0 : cyc_q + 1'b1;
          ms_d  = tick ? ms_q + 12'd1 : ms_q;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (advance) begin
      if (idx_q == IDX_LAST) begin
        end_seq = 1'b1;
      end else begin
        idx_d   = idx_q + 1'b1;
        state_d = S_LOAD;
      end
    end

    // Looping requires at least one real note, otherwise an all-empty table would spin forever.
    if (end_seq) begin
      if (loop && played_q) begin
        idx_d   = '0;
        state_d = S_LOAD;
      end else begin
        state_d = S_IDLE;
        done_d  = 1'b1;
      end
    end

    if (stop && state_q != S_IDLE) begin
      state_d   = S_IDLE;
      idx_d     = idx_q;
      tone_en_d = 1'b0;
      period_d  = '0;
      done_d    = 1'b0;
      cyc_d     = '0;
      ms_d      = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      dur_q     <= '0;
      period_q  <= '0;
      tone_en_q <= 1'b0;
      done_q    <= 1'b0;
      played_q  <= 1'b0;
      cyc_q     <= '0;
      ms_q      <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      dur_q     <= dur_d;
      period_q  <= period_d;
      tone_en_q <= tone_en_d;
      done_q    <= done_d;
      played_q  <= played_d;
      cyc_q     <= cyc_d;
      ms_q      <= ms_d;
    end
  end

  assign period   = tone_en_q ? {16'd0, period_q} : 32'd0;
  assign tone_en  = tone_en_q;
  assign busy     = (state_q != S_IDLE);
  assign note_idx = idx_q;
  assign done     = done_q;

endmodule

// File: tb/tb_tone_sequencer.sv
// Directed bench for tone_sequencer with T=4 cycles/ms, 1 ms gap, 8 entries.
// Every cycle of each scenario is compared against a hand-derived output timeline.
module tb_tone_sequencer;

  logic        CLK;
  logic        RST;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_period;
  logic [11:0] wr_dur;
  logic        start;
  logic        stop;
  logic        loop;
  logic [31:0] period;
  logic        tone_en;
  logic        busy;
  logic [2:0]  note_idx;
  logic        done;

  int checks   = 0;
  int failures = 0;

  tone_sequencer #(
    .CLKS_PER_US(1),
    .US_PER_MS  (4),
    .GAP_MS     (1),
    .DEPTH      (8)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_period(wr_period),
    .wr_dur   (wr_dur),
    .start    (start),
    .stop     (stop),
    .loop     (loop),
    .period   (period),
    .tone_en  (tone_en),
    .busy     (busy),
    .note_idx (note_idx),
    .done     (done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Check all outputs for n consecutive cycles, advancing one clock after each.
  task automatic seg(input string tag, input int n, input logic te, input logic [31:0] per,
                     input logic [2:0] idx, input logic bz, input logic dn);
    for (int k = 0; k < n; k++) begin
      chk($sformatf("%s[%0d].tone_en", tag, k), {31'd0, tone_en}, {31'd0, te});
      chk($sformatf("%s[%0d].period", tag, k), period, per);
      chk($sformatf("%s[%0d].note_idx", tag, k), {29'd0, note_idx}, {29'd0, idx});
      chk($sformatf("%s[%0d].busy", tag, k), {31'd0, busy}, {31'd0, bz});
      chk($sformatf("%s[%0d].done", tag, k), {31'd0, done}, {31'd0, dn});
      step();
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] p, input logic [11:0] d);
    wr_en     = 1'b1;
    wr_addr   = a;
    wr_period = p;
    wr_dur    = d;
    step();
    wr_en     = 1'b0;
  endtask

  task automatic kick();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  // Entries {1000,2},{0,1},{80,3},{x,0}: from first PLAY cycle through LOAD of entry 3.
  task automatic pass_body(input string tag);
    seg({tag, "_p0"}, 8,  1'b1, 1000, 3'd0, 1'b1, 1'b0);
    seg({tag, "_g0"}, 4,  1'b0, 0,    3'd0, 1'b1, 1'b0);
    seg({tag, "_l1"}, 1,  1'b0, 0,    3'd1, 1'b1, 1'b0);
    seg({tag, "_p1"}, 4,  1'b0, 0,    3'd1, 1'b1, 1'b0);
    seg({tag, "_g1"}, 4,  1'b0, 0,    3'd1, 1'b1, 1'b0);
    seg({tag, "_l2"}, 1,  1'b0, 0,    3'd2, 1'b1, 1'b0);
    seg({tag, "_p2"}, 12, 1'b1, 80,   3'd2, 1'b1, 1'b0);
    seg({tag, "_g2"}, 4,  1'b0, 0,    3'd2, 1'b1, 1'b0);
    seg({tag, "_l3"}, 1,  1'b0, 0,    3'd3, 1'b1, 1'b0);
  endtask

  initial begin
    RST = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_period = '0; wr_dur = '0;
    start = 1'b0; stop = 1'b0; loop = 1'b0;
    step();
    seg("reset", 1, 1'b0, 0, 3'd0, 1'b0, 1'b0);
    RST = 1'b0;

    // Reset while a note is sounding, then an empty sequence.
    wr(3'd0, 16'd1000, 12'd2);
    wr(3'd1, 16'd0,    12'd1);
    wr(3'd2, 16'd80,   12'd3);
    wr(3'd3, 16'd1234, 12'd0);
    kick();
    seg("t1_ld", 1, 1'b0, 0,    3'd0, 1'b1, 1'b0);
    seg("t1_p",  3, 1'b1, 1000, 3'd0, 1'b1, 1'b0);
    RST = 1'b1;
    step();
    RST = 1'b0;
    seg("t1_rst", 1, 1'b0, 0, 3'd0, 1'b0, 1'b0);
    wr(3'd0, 16'd555, 12'd0);
    kick();
    seg("t1_ld0",  1, 1'b0, 0, 3'd0, 1'b1, 1'b0);
    seg("t1_done", 1, 1'b0, 0, 3'd0, 1'b0, 1'b1);
    seg("t1_idle", 2, 1'b0, 0, 3'd0, 1'b0, 1'b0);

    // Single pass, no loop.
    wr(3'd0, 16'd1000, 12'd2);
    kick();
    seg("t2_l0", 1, 1'b0, 0, 3'd0, 1'b1, 1'b0);
    pass_body("t2");
    seg("t2_done", 1, 1'b0, 0, 3'd3, 1'b0, 1'b1);
    seg("t2_idle", 1, 1'b0, 0, 3'd3, 1'b0, 1'b0);

    // Loop once, then let it finish.
    loop = 1'b1;
    kick();
    seg("t3_l0a", 1, 1'b0, 0, 3'd0, 1'b1, 1'b0);
    pass_body("t3a");
    seg("t3_l0b", 1, 1'b0, 0, 3'd0, 1'b1, 1'b0);
    loop = 1'b0;
    pass_body("t3b");
    seg("t3_done", 1, 1'b0, 0, 3'd3, 1'b0, 1'b1);
    seg("t3_idle", 1, 1'b0, 0, 3'd3, 1'b0, 1'b0);

    // Stop in the third PLAY cycle of entry 0, then restart.
    kick();
    seg("t4_ld", 1, 1'b0, 0,    3'd0, 1'b1, 1'b0);
    seg("t4_p",  2, 1'b1, 1000, 3'd0, 1'b1, 1'b0);
    stop = 1'b1;
    seg("t4_p3", 1, 1'b1, 1000, 3'd0, 1'b1, 1'b0);
    stop = 1'b0;
    seg("t4_stop", 3, 1'b0, 0, 3'd0, 1'b0, 1'b0);
    kick();
    seg("t4_rld", 1, 1'b0, 0,    3'd0, 1'b1, 1'b0);
    seg("t4_rp",  2, 1'b1, 1000, 3'd0, 1'b1, 1'b0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    seg("t4_rstop", 1, 1'b0, 0, 3'd0, 1'b0, 1'b0);

    // Full 8-entry table, start pulses during playback are ignored.
    for (int i = 0; i < 8; i++) wr(3'(i), 16'(100 + i), 12'd1);
    kick();
    for (int i = 0; i < 8; i++) begin
      seg($sformatf("t5_l%0d", i), 1, 1'b0, 0, 3'(i), 1'b1, 1'b0);
      start = (i == 3);
      seg($sformatf("t5_p%0d", i), 4, 1'b1, 32'(100 + i), 3'(i), 1'b1, 1'b0);
      start = (i == 6);
      seg($sformatf("t5_g%0d", i), 4, 1'b0, 0, 3'(i), 1'b1, 1'b0);
      start = 1'b0;
    end
    seg("t5_done", 1, 1'b0, 0, 3'd7, 1'b0, 1'b1);
    seg("t5_idle", 1, 1'b0, 0, 3'd7, 1'b0, 1'b0);
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    seg("t5_ss", 2, 1'b0, 0, 3'd7, 1'b0, 1'b0);

    // Rewrite the entry that is currently playing.
    wr(3'd0, 16'd1000, 12'd2);
    wr(3'd1, 16'd80,   12'd3);
    wr(3'd2, 16'd7,    12'd0);
    loop = 1'b1;
    kick();
    seg("t6_l0", 1, 1'b0, 0,    3'd0, 1'b1, 1'b0);
    seg("t6_p0", 8, 1'b1, 1000, 3'd0, 1'b1, 1'b0);
    seg("t6_g0", 4, 1'b0, 0,    3'd0, 1'b1, 1'b0);
    seg("t6_l1", 1, 1'b0, 0,    3'd1, 1'b1, 1'b0);
    wr_en = 1'b1; wr_addr = 3'd1; wr_period = 16'd500; wr_dur = 12'd1;
    seg("t6_p1w", 1, 1'b1, 80, 3'd1, 1'b1, 1'b0);
    wr_en = 1'b0;
    seg("t6_p1",  11, 1'b1, 80,   3'd1, 1'b1, 1'b0);
    seg("t6_g1",  4,  1'b0, 0,    3'd1, 1'b1, 1'b0);
    seg("t6_l2",  1,  1'b0, 0,    3'd2, 1'b1, 1'b0);
    seg("t6_l0b", 1,  1'b0, 0,    3'd0, 1'b1, 1'b0);
    seg("t6_p0b", 8,  1'b1, 1000, 3'd0, 1'b1, 1'b0);
    seg("t6_g0b", 4,  1'b0, 0,    3'd0, 1'b1, 1'b0);
    seg("t6_l1b", 1,  1'b0, 0,    3'd1, 1'b1, 1'b0);
    loop = 1'b0;
    seg("t6_p1b", 4,  1'b1, 500,  3'd1, 1'b1, 1'b0);
    seg("t6_g1b", 4,  1'b0, 0,    3'd1, 1'b1, 1'b0);
    seg("t6_l2b", 1,  1'b0, 0,    3'd2, 1'b1, 1'b0);
    seg("t6_done", 1, 1'b0, 0,    3'd2, 1'b0, 1'b1);
    seg("t6_idle", 1, 1'b0, 0,    3'd2, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
